// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and widths for the program-image loader.
// Optional checksum feature is selected with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

    localparam int PL_INSTR_W       = 12;
    localparam int PL_HI_NIBBLE_MSB = 3;
    localparam int PL_BYTE_W        = 8;

    // CHK and ERR are only reachable when PROG_LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        PL_IDLE,
        PL_HI,
        PL_LO,
        PL_WRITE,
        PL_CHK,
        PL_DONE,
        PL_ERR
    } pl_state_t;

endpackage

// File: rtl/pl_csum.sv
// pl_csum: 8-bit running sum of image bytes with a zero-total compare.
// Instantiated by prog_loader only when PROG_LOADER_CHECKSUM_EN is defined.
module pl_csum
    import prog_loader_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    input  logic                 i_add,
    input  logic [PL_BYTE_W-1:0] i_data,
    output logic                 o_match
);

    logic [PL_BYTE_W-1:0] r_sum;
    logic [PL_BYTE_W-1:0] w_total;

    // Accumulate every accepted image byte; a new load clears the sum.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    // The checksum byte is the two's complement of the sum, so a good image totals zero.
    assign w_total = r_sum + i_data;
    assign o_match = (w_total == '0);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams byte pairs into 12-bit instructions and writes them
// through the program-memory load port. PROG_LOADER_CHECKSUM_EN adds a
// trailing checksum byte (CHK) and a sticky error state (ERR).
//
// state | meaning
// IDLE  | waiting for start after reset, address held at 0
// HI    | waiting for the high-nibble byte
// LO    | waiting for the low byte
// WRITE | one-cycle load pulse to program memory
// CHK   | waiting for the checksum byte (checksum build only)
// DONE  | image loaded and valid
// ERR   | checksum mismatch (checksum build only)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int PMEM_DEPTH = 10,
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = PL_INSTR_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_in_valid,
    input  logic [PL_BYTE_W-1:0] i_in_data,
    output logic                 o_in_ready,
    output logic                 o_pmem_le,
    output logic [ADDR_W-1:0]    o_pmem_la,
    output logic [INSTR_W-1:0]   o_pmem_li,
    output logic                 o_load_done,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

    pl_state_t                 r_state;
    logic [ADDR_W-1:0]         r_addr;
    logic [PL_HI_NIBBLE_MSB:0] r_hi;
    logic                      r_in_ready;
    logic                      r_pmem_le;
    logic [ADDR_W-1:0]         r_pmem_la;
    logic [INSTR_W-1:0]        r_pmem_li;
    logic                      r_load_done;
    logic                      r_busy;
    logic                      w_accept;

    assign w_accept = i_in_valid && r_in_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic r_err;
    logic w_start_ok;
    logic w_csum_add;
    logic w_csum_match;

    assign w_start_ok = i_start && ((r_state == PL_IDLE) || (r_state == PL_DONE) ||
                                    (r_state == PL_ERR));
    assign w_csum_add = w_accept && ((r_state == PL_HI) || (r_state == PL_LO));

    pl_csum u_csum (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_start_ok),
        .i_add   (w_csum_add),
        .i_data  (i_in_data),
        .o_match (w_csum_match)
    );

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

    // Load sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= PL_IDLE;
            r_addr      <= '0;
            r_hi        <= '0;
            r_in_ready  <= 1'b0;
            r_pmem_le   <= 1'b0;
            r_pmem_la   <= '0;
            r_pmem_li   <= '0;
            r_load_done <= 1'b0;
            r_busy      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_pmem_le <= 1'b0;
            case (r_state)
                PL_IDLE, PL_DONE, PL_ERR: begin
                    if (i_start) begin
                        r_state     <= PL_HI;
                        r_addr      <= '0;
                        r_load_done <= 1'b0;
                        r_busy      <= 1'b1;
                        r_in_ready  <= 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                PL_HI: begin
                    if (w_accept) begin
                        r_hi    <= i_in_data[PL_HI_NIBBLE_MSB:0];
                        r_state <= PL_LO;
                    end
                end
                PL_LO: begin
                    if (w_accept) begin
                        r_pmem_le  <= 1'b1;
                        r_pmem_la  <= r_addr;
                        r_pmem_li  <= {r_hi, i_in_data};
                        r_in_ready <= 1'b0;
                        r_state    <= PL_WRITE;
                    end
                end
                PL_WRITE: begin
                    r_in_ready <= 1'b1;
                    if (r_addr == LAST_ADDR) begin
                        r_addr <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_state <= PL_CHK;
`else
                        r_state     <= PL_DONE;
                        r_in_ready  <= 1'b0;
                        r_load_done <= 1'b1;
                        r_busy      <= 1'b0;
`endif
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= PL_HI;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                PL_CHK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        if (w_csum_match) begin
                            r_state     <= PL_DONE;
                            r_load_done <= 1'b1;
                        end else begin
                            r_state <= PL_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= PL_IDLE;
                    r_addr     <= '0;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_pmem_le   = r_pmem_le;
    assign o_pmem_la   = r_pmem_la;
    assign o_pmem_li   = r_pmem_li;
    assign o_load_done = r_load_done;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// Follows PROG_LOADER_CHECKSUM_EN so the checksum byte is appended when enabled.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int DEPTH = 10;
    localparam int AW    = 8;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic            pmem_le;
    logic [AW-1:0]   pmem_la;
    logic [11:0]     pmem_li;
    logic            load_done;
    logic            busy;
    logic            err;

    always #5 clk = ~clk;

    prog_loader #(.PMEM_DEPTH(DEPTH), .ADDR_W(AW), .INSTR_W(PL_INSTR_W)) u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_in_valid  (in_valid),
        .i_in_data   (in_data),
        .o_in_ready  (in_ready),
        .o_pmem_le   (pmem_le),
        .o_pmem_la   (pmem_la),
        .o_pmem_li   (pmem_li),
        .o_load_done (load_done),
        .o_busy      (busy),
        .o_err       (err)
    );

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] li;
    } vec_t;

    vec_t        tbl[DEPTH];
    logic [7:0]  hi_b[DEPTH];
    logic [7:0]  lo_b[DEPTH];
    logic [11:0] exp_li[DEPTH];
    logic [7:0]  bytes[$];
    logic [19:0] wq[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Every write pulse seen on the load port, as {address, instruction}.
    always @(negedge clk) begin
        if (pmem_le === 1'b1) wq.push_back({pmem_la, pmem_li});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte stream for the current hi_b/lo_b image; expected instructions from plain arithmetic.
    task automatic build_image(input bit bad_csum);
        int sum;
        sum = 0;
        bytes.delete();
        for (int i = 0; i < DEPTH; i++) begin
            bytes.push_back(hi_b[i]);
            bytes.push_back(lo_b[i]);
            sum = sum + int'(hi_b[i]) + int'(lo_b[i]);
            exp_li[i] = 12'((int'(hi_b[i]) % 16) * 256 + int'(lo_b[i]));
        end
        if (CS == 1) bytes.push_back(8'((256 - (sum % 256) + (bad_csum ? 255 : 0)) % 256));
    endtask

    task automatic run_load(input int stall_at, input int stall_len, input int start_at,
                            input bit rand_stall, input int abort_n,
                            output int cycles, output int stalls);
        int idx;
        int rem;
        int st_at;
        bit acc;
        idx = 0;
        rem = stall_len;
        st_at = start_at;
        cycles = 0;
        stalls = 0;
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        check("busy_rise", busy, 1);
        check("ready_rise", in_ready, 1);
        check("done_drop", load_done, 0);
        while (!load_done && !err && wq.size() < abort_n && cycles < 2000) begin
            in_valid = 1'b0;
            acc = 1'b0;
            if (idx < bytes.size() && in_ready) begin
                if (idx == stall_at && rem > 0) begin
                    rem--;
                    stalls++;
                end else if (rand_stall && $urandom_range(3) == 0) begin
                    stalls++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = bytes[idx];
                    acc      = 1'b1;
                end
            end
            if (idx == st_at) begin
                start = 1'b1;
                st_at = -1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("load_timeout", cycles < 2000, 1);
    endtask

    task automatic verify_writes(input string tag);
        check({tag, "_nwrites"}, wq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < wq.size(); i++) begin
            check({tag, "_la"}, wq[i][19:12], i);
            check({tag, "_li"}, wq[i][11:0], exp_li[i]);
        end
    endtask

    task automatic check_done(input string tag);
        check({tag, "_load_done"}, load_done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, in_ready, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        int cyc;
        int stl;
        tbl[0] = '{8'h0A, 8'h05, 12'hA05};
        tbl[1] = '{8'h01, 8'h23, 12'h123};
        tbl[2] = '{8'hF7, 8'h42, 12'h742};
        tbl[3] = '{8'h00, 8'h00, 12'h000};
        tbl[4] = '{8'hFF, 8'hFF, 12'hFFF};
        tbl[5] = '{8'h5C, 8'h3A, 12'hC3A};
        tbl[6] = '{8'h80, 8'h01, 12'h001};
        tbl[7] = '{8'h0B, 8'hCD, 12'hBCD};
        tbl[8] = '{8'h36, 8'h99, 12'h699};
        tbl[9] = '{8'hE4, 8'h10, 12'h410};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #12;
        check("rst_ready", in_ready, 0);
        check("rst_le", pmem_le, 0);
        check("rst_la", pmem_la, 0);
        check("rst_li", pmem_li, 0);
        check("rst_done", load_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Valid in IDLE is ignored.
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        check("idle_nowrite", wq.size(), 0);

        // Table-driven image, no stalls.
        for (int i = 0; i < DEPTH; i++) begin
            hi_b[i] = tbl[i].hi;
            lo_b[i] = tbl[i].lo;
        end
        build_image(1'b0);
        run_load(-1, 0, -1, 1'b0, DEPTH + 1, cyc, stl);
        check("tbl_cycles", cyc, 3 * DEPTH + 1 + CS);
        check("tbl_nwrites", wq.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < wq.size(); i++) begin
            check("tbl_la", wq[i][19:12], i);
            check("tbl_li", wq[i][11:0], tbl[i].li);
        end
        check_done("tbl");
        check("hold_la", pmem_la, DEPTH - 1);
        check("hold_li", pmem_li, tbl[DEPTH-1].li);

        // Restart from DONE with a 5-cycle stall between HI and LO of instruction 3.
        run_load(7, 5, -1, 1'b0, DEPTH + 1, cyc, stl);
        check("stall_cycles", cyc, 3 * DEPTH + 1 + CS + 5);
        verify_writes("stall");
        check_done("stall");

        // Start pulsed during LO of instruction 2 is ignored.
        run_load(-1, 0, 5, 1'b0, DEPTH + 1, cyc, stl);
        check("lostart_cycles", cyc, 3 * DEPTH + 1 + CS);
        verify_writes("lostart");
        check_done("lostart");

        // Random images with random stalls.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                hi_b[i] = 8'($urandom_range(255));
                lo_b[i] = 8'($urandom_range(255));
            end
            build_image(1'b0);
            run_load(-1, 0, -1, 1'b1, DEPTH + 1, cyc, stl);
            check("rand_cycles", cyc, 3 * DEPTH + 1 + CS + stl);
            verify_writes("rand");
            check_done("rand");
        end

        // Asynchronous reset after the 4th write, then a full reload.
        run_load(-1, 0, -1, 1'b0, 4, cyc, stl);
        check("abort_nwrites", wq.size(), 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ready", in_ready, 0);
        check("arst_le", pmem_le, 0);
        check("arst_la", pmem_la, 0);
        check("arst_li", pmem_li, 0);
        check("arst_done", load_done, 0);
        check("arst_busy", busy, 0);
        check("arst_err", err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_load(-1, 0, -1, 1'b0, DEPTH + 1, cyc, stl);
        check("reload_cycles", cyc, 3 * DEPTH + 1 + CS);
        verify_writes("reload");
        check_done("reload");

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum byte lands in ERR; a good load afterwards clears it.
        build_image(1'b1);
        run_load(-1, 0, -1, 1'b0, DEPTH + 1, cyc, stl);
        verify_writes("bad");
        check("bad_err", err, 1);
        check("bad_done", load_done, 0);
        check("bad_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("bad_err_sticky", err, 1);
        build_image(1'b0);
        run_load(-1, 0, -1, 1'b0, DEPTH + 1, cyc, stl);
        verify_writes("good");
        check_done("good");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
